// File: rtl/iob_ibex_axi_mem_rsp.sv
// iob_ibex_axi_mem_rsp: AXI4 responder in front of a single-port synchronous word RAM.
// Serves one transaction at a time (write wins ties), FIXED/INCR bursts, and answers anything
// else with SLVERR while still consuming/returning every beat without touching memory.
module iob_ibex_axi_mem_rsp #(
  parameter int unsigned AXI_ID_W   = 1,
  parameter int unsigned AXI_ADDR_W = 24,
  parameter int unsigned AXI_DATA_W = 32,
  parameter int unsigned AXI_LEN_W  = 8,
  localparam int unsigned MEM_ADDR_W = AXI_ADDR_W - 2,
  localparam int unsigned STRB_W     = AXI_DATA_W / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // write address
  input  logic [AXI_ID_W-1:0]   axi_awid_i,
  input  logic [AXI_ADDR_W-1:0] axi_awaddr_i,
  input  logic [AXI_LEN_W-1:0]  axi_awlen_i,
  input  logic [2:0]            axi_awsize_i,
  input  logic [1:0]            axi_awburst_i,
  input  logic                  axi_awvalid_i,
  output logic                  axi_awready_o,
  // write data
  input  logic [AXI_DATA_W-1:0] axi_wdata_i,
  input  logic [STRB_W-1:0]     axi_wstrb_i,
  input  logic                  axi_wlast_i,
  input  logic                  axi_wvalid_i,
  output logic                  axi_wready_o,
  // write response
  output logic [AXI_ID_W-1:0]   axi_bid_o,
  output logic [1:0]            axi_bresp_o,
  output logic                  axi_bvalid_o,
  input  logic                  axi_bready_i,
  // read address
  input  logic [AXI_ID_W-1:0]   axi_arid_i,
  input  logic [AXI_ADDR_W-1:0] axi_araddr_i,
  input  logic [AXI_LEN_W-1:0]  axi_arlen_i,
  input  logic [2:0]            axi_arsize_i,
  input  logic [1:0]            axi_arburst_i,
  input  logic                  axi_arvalid_i,
  output logic                  axi_arready_o,
  // read data
  output logic [AXI_ID_W-1:0]   axi_rid_o,
  output logic [AXI_DATA_W-1:0] axi_rdata_o,
  output logic [1:0]            axi_rresp_o,
  output logic                  axi_rlast_o,
  output logic                  axi_rvalid_o,
  input  logic                  axi_rready_i,
  // memory
  output logic                  mem_en_o,
  output logic [STRB_W-1:0]     mem_we_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  output logic [AXI_DATA_W-1:0] mem_wdata_o,
  input  logic [AXI_DATA_W-1:0] mem_rdata_i
);

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StWrData,
    StWrResp,
    StRdMem,
    StRdLat,
    StRdData
  } state_e;

  state_e                state_q;
  logic [AXI_ID_W-1:0]   id_q;
  logic [MEM_ADDR_W-1:0] addr_q;
  logic [AXI_LEN_W-1:0]  len_q;
  logic [AXI_LEN_W-1:0]  cnt_q;
  logic                  incr_q;
  logic                  err_q;
  logic [AXI_DATA_W-1:0] rdata_q;

  logic                  run;
  logic                  last_beat;
  logic [MEM_ADDR_W-1:0] addr_nxt;
  logic                  aw_hs;
  logic                  ar_hs;
  logic                  w_hs;
  logic                  r_hs;

  // Byte-lane offset bits are meaningless for a word memory.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{axi_awaddr_i[1:0], axi_araddr_i[1:0]};

  function automatic logic bad_req(input logic [2:0] size, input logic [1:0] burst);
    return ((burst != BurstFixed) && (burst != BurstIncr)) || (size != 3'd2);
  endfunction

  // Handshake qualifiers and next beat address; reset masks every handshake.
  always_comb begin
    run       = !rst_i;
    last_beat = (cnt_q == len_q);
    addr_nxt  = incr_q ? addr_q + MEM_ADDR_W'(1) : addr_q;
    aw_hs     = run && (state_q == StIdle) && axi_awvalid_i;
    ar_hs     = run && (state_q == StIdle) && axi_arvalid_i && !axi_awvalid_i;
    w_hs      = run && (state_q == StWrData) && axi_wvalid_i;
    r_hs      = run && (state_q == StRdData) && axi_rready_i;
  end

  // Transaction FSM with latched request fields, beat counter and read data holding register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      incr_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (aw_hs) begin
            id_q    <= axi_awid_i;
            addr_q  <= axi_awaddr_i[AXI_ADDR_W-1:2];
            len_q   <= axi_awlen_i;
            incr_q  <= (axi_awburst_i == BurstIncr);
            err_q   <= bad_req(axi_awsize_i, axi_awburst_i);
            cnt_q   <= '0;
            state_q <= StWrData;
          end else if (ar_hs) begin
            id_q    <= axi_arid_i;
            addr_q  <= axi_araddr_i[AXI_ADDR_W-1:2];
            len_q   <= axi_arlen_i;
            incr_q  <= (axi_arburst_i == BurstIncr);
            err_q   <= bad_req(axi_arsize_i, axi_arburst_i);
            cnt_q   <= '0;
            state_q <= StRdMem;
          end
        end
        StWrData: begin
          if (w_hs) begin
            // A misplaced wlast poisons the response but the burst length still rules.
            if (axi_wlast_i != last_beat) err_q <= 1'b1;
            if (last_beat) begin
              state_q <= StWrResp;
            end else begin
              cnt_q  <= cnt_q + AXI_LEN_W'(1);
              addr_q <= addr_nxt;
            end
          end
        end
        StWrResp: begin
          if (axi_bready_i) state_q <= StIdle;
        end
        StRdMem: begin
          state_q <= StRdLat;
        end
        StRdLat: begin
          rdata_q <= err_q ? '0 : mem_rdata_i;
          state_q <= StRdData;
        end
        StRdData: begin
          if (r_hs) begin
            if (last_beat) begin
              state_q <= StIdle;
            end else begin
              cnt_q   <= cnt_q + AXI_LEN_W'(1);
              addr_q  <= addr_nxt;
              state_q <= StRdLat;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // AXI channel outputs decoded from the registered state.
  always_comb begin
    axi_awready_o = run && (state_q == StIdle);
    axi_arready_o = run && (state_q == StIdle) && !axi_awvalid_i;
    axi_wready_o  = run && (state_q == StWrData);
    axi_bvalid_o  = run && (state_q == StWrResp);
    axi_bid_o     = id_q;
    axi_bresp_o   = ((state_q == StWrResp) && err_q) ? RespSlverr : RespOkay;
    axi_rvalid_o  = run && (state_q == StRdData);
    axi_rid_o     = id_q;
    axi_rdata_o   = rdata_q;
    axi_rresp_o   = ((state_q == StRdData) && err_q) ? RespSlverr : RespOkay;
    axi_rlast_o   = (state_q == StRdData) && last_beat;
  end

  // Memory port; the next read of a burst is launched in the same cycle as the R handshake.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = '0;
    mem_addr_o  = addr_q;
    mem_wdata_o = axi_wdata_i;
    unique case (state_q)
      StWrData: begin
        if (w_hs && !err_q) begin
          mem_en_o = 1'b1;
          mem_we_o = axi_wstrb_i;
        end
      end
      StRdMem: begin
        mem_en_o = run && !err_q;
      end
      StRdData: begin
        if (r_hs && !last_beat) begin
          mem_addr_o = addr_nxt;
          mem_en_o   = !err_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_iob_ibex_axi_mem_rsp.sv
// Self-checking bench for iob_ibex_axi_mem_rsp: directed scenarios plus a randomized mix, with a
// word-level memory model indexed by burst beat address.
module tb_iob_ibex_axi_mem_rsp;

  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:0]  awid;
  logic [23:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [0:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [0:0]  arid;
  logic [23:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [0:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [21:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_err = 0;
  int mem_en_cnt = 0;

  logic [31:0] ram [0:4095];
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] wdat [0:255];
  logic [3:0]  wstb [0:255];

  always #5 clk = ~clk;

  iob_ibex_axi_mem_rsp dut (
    .clk_i(clk), .rst_i(rst),
    .axi_awid_i(awid), .axi_awaddr_i(awaddr), .axi_awlen_i(awlen), .axi_awsize_i(awsize),
    .axi_awburst_i(awburst), .axi_awvalid_i(awvalid), .axi_awready_o(awready),
    .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wlast_i(wlast), .axi_wvalid_i(wvalid),
    .axi_wready_o(wready),
    .axi_bid_o(bid), .axi_bresp_o(bresp), .axi_bvalid_o(bvalid), .axi_bready_i(bready),
    .axi_arid_i(arid), .axi_araddr_i(araddr), .axi_arlen_i(arlen), .axi_arsize_i(arsize),
    .axi_arburst_i(arburst), .axi_arvalid_i(arvalid), .axi_arready_o(arready),
    .axi_rid_o(rid), .axi_rdata_o(rdata), .axi_rresp_o(rresp), .axi_rlast_o(rlast),
    .axi_rvalid_o(rvalid), .axi_rready_i(rready),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  // Synchronous RAM: read data valid only in the cycle after a read, garbage otherwise.
  always @(posedge clk) begin
    if (mem_en) begin
      mem_en_cnt <= mem_en_cnt + 1;
      if (mem_we == 4'h0) begin
        mem_rdata <= ram[mem_addr[11:0]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) ram[mem_addr[11:0]][8*b +: 8] = mem_wdata[8*b +: 8];
        mem_rdata <= $urandom;
      end
    end else begin
      mem_rdata <= $urandom;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1);
  end

  function automatic logic [31:0] ref_rd(input int unsigned w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  // Word touched by beat i of a burst: INCR steps one word and wraps at 2^22 words.
  function automatic int unsigned beat_word(input logic [23:0] a, input logic [1:0] burst,
                                            input int i);
    int unsigned w;
    w = int'(a[23:2]);
    if (burst == 2'b01) w = (w + i) % 32'h0040_0000;
    return w;
  endfunction

  function automatic bit is_err(input logic [2:0] size, input logic [1:0] burst);
    return !(burst == 2'b00 || burst == 2'b01) || (size != 3'd2);
  endfunction

  task automatic axi_write(input logic id, input logic [23:0] a, input int len,
                           input logic [2:0] size, input logic [1:0] burst, input int bdelay,
                           input bit chk_ar);
    int n;
    bit err;
    logic [31:0] tmp;
    int unsigned w;
    err = is_err(size, burst);
    awid = id; awaddr = a; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1'b1;
    #1;
    if (chk_ar) begin
      n_cmp++;
      if (arready !== 1'b0 || awready !== 1'b1) begin
        n_err++;
        $display("FAIL prio_ready: got aw=%b ar=%b, required aw=1 ar=0", awready, arready);
      end
    end
    n = 0;
    while (awready !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) begin n_cmp++; n_err++; $display("FAIL aw_timeout: got no awready"); end
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wdata = wdat[i]; wstrb = wstb[i]; wlast = (i == len); wvalid = 1'b1;
      n = 0;
      while (wready !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
      if (n >= TMO) begin n_cmp++; n_err++; $display("FAIL w_timeout: beat %0d", i); end
      if (!err) begin
        w = beat_word(a, burst, i);
        tmp = ref_rd(w);
        for (int b = 0; b < 4; b++) if (wstb[i][b]) tmp[8*b +: 8] = wdat[i][8*b +: 8];
        ref_mem[w] = tmp;
      end
      @(negedge clk);
      if (chk_ar) begin
        n_cmp++;
        if (arready !== 1'b0) begin
          n_err++;
          $display("FAIL ar_blocked: got arready=%b during write, required 0", arready);
        end
      end
    end
    wvalid = 1'b0; wlast = 1'b0;
    repeat (bdelay) @(negedge clk);
    bready = 1'b1;
    n = 0;
    while (bvalid !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
    n_cmp++;
    if (n >= TMO || {bid, bresp} !== {id, (err ? 2'b10 : 2'b00)}) begin
      n_err++;
      $display("FAIL bresp: got bvalid=%b bid=%h bresp=%b, required bvalid=1 bid=%h bresp=%b",
               bvalid, bid, bresp, id, err ? 2'b10 : 2'b00);
    end
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic id, input logic [23:0] a, input int len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int stall_lo, input int stall_hi);
    int n, lat, k, en0;
    bit err;
    logic [31:0] exp_d;
    logic [35:0] snap;
    err = is_err(size, burst);
    arid = id; araddr = a; arlen = 8'(len); arsize = size; arburst = burst; arvalid = 1'b1;
    #1;
    n = 0;
    while (arready !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) begin n_cmp++; n_err++; $display("FAIL ar_timeout: got no arready"); end
    @(negedge clk);
    arvalid = 1'b0;
    lat = 1;
    for (int i = 0; i <= len; i++) begin
      n = 0;
      while (rvalid !== 1'b1 && n < TMO) begin @(negedge clk); n++; lat++; end
      if (n >= TMO) begin n_cmp++; n_err++; $display("FAIL r_timeout: beat %0d", i); end
      if (i == 0) begin
        n_cmp++;
        if (lat != 3) begin
          n_err++;
          $display("FAIL r_latency: got %0d cycles, required 3", lat);
        end
      end
      exp_d = err ? 32'h0 : ref_rd(beat_word(a, burst, i));
      k = $urandom_range(stall_hi, stall_lo);
      if (k > 0) begin
        snap = {rid, rdata, rresp, rlast};
        en0 = mem_en_cnt;
        repeat (k) @(negedge clk);
        n_cmp++;
        if (rvalid !== 1'b1 || {rid, rdata, rresp, rlast} !== snap || mem_en_cnt != en0) begin
          n_err++;
          $display("FAIL r_stall: got valid=%b beat=%h en=%0d, required valid=1 beat=%h en=%0d",
                   rvalid, {rid, rdata, rresp, rlast}, mem_en_cnt, snap, en0);
        end
      end
      n_cmp++;
      if ({rid, rdata, rresp, rlast} !== {id, exp_d, (err ? 2'b10 : 2'b00), (i == len)}) begin
        n_err++;
        $display("FAIL r_beat%0d: got id=%h data=%h resp=%b last=%b, required %h %h %b %b",
                 i, rid, rdata, rresp, rlast, id, exp_d, err ? 2'b10 : 2'b00, (i == len));
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({awready, arready, wready, bvalid, rvalid, mem_en, mem_we, bid, rid, bresp, rresp,
         rdata, rlast} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got nonzero aw=%b ar=%b w=%b b=%b r=%b en=%b we=%h rd=%h",
               awready, arready, wready, bvalid, rvalid, mem_en, mem_we, rdata);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({awready, arready, wready} !== 3'b110) begin
      n_err++;
      $display("FAIL idle_ready: got aw/ar/w=%b%b%b, required 110", awready, arready, wready);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    wdat[0] = 32'hDEAD_BEEF; wstb[0] = 4'hF;
    axi_write(1'b1, 24'h10, 0, 3'd2, 2'b01, 0, 1'b0);
    n_cmp++;
    if (ram[4] !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL single_mem: got word4=%h, required deadbeef", ram[4]);
    end
    axi_read(1'b1, 24'h10, 0, 3'd2, 2'b01, 0, 0);
  endtask

  task automatic test_burst();
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'(i + 1); wstb[i] = 4'hF; end
    wdat[2] = 32'hAAAA_5555; wstb[2] = 4'h3;
    axi_write(1'b0, 24'h20, 3, 3'd2, 2'b01, 1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (ram[8 + i] !== ref_rd(32'(8 + i))) begin
        n_err++;
        $display("FAIL burst_mem%0d: got %h, required %h", i, ram[8 + i], ref_rd(32'(8 + i)));
      end
    end
    axi_read(1'b0, 24'h20, 3, 3'd2, 2'b01, 0, 0);
  endtask

  task automatic test_priority();
    arid = 1'b1; araddr = 24'h24; arlen = 8'd1; arsize = 3'd2; arburst = 2'b01;
    arvalid = 1'b1;
    wdat[0] = 32'h1234_5678; wstb[0] = 4'hF;
    wdat[1] = 32'h9ABC_DEF0; wstb[1] = 4'hF;
    axi_write(1'b0, 24'h24, 1, 3'd2, 2'b01, 2, 1'b1);
    n_cmp++;
    if (arready !== 1'b1) begin
      n_err++;
      $display("FAIL ar_after_b: got arready=%b, required 1", arready);
    end
    axi_read(1'b1, 24'h24, 1, 3'd2, 2'b01, 0, 0);
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
    axi_write(1'b1, 24'h40, 3, 3'd2, 2'b01, 0, 1'b0);
    axi_read(1'b1, 24'h40, 3, 3'd2, 2'b01, 5, 5);
  endtask

  task automatic test_error();
    int en0;
    en0 = mem_en_cnt;
    wdat[0] = 32'hFFFF_FFFF; wstb[0] = 4'hF;
    wdat[1] = 32'hEEEE_EEEE; wstb[1] = 4'hF;
    axi_write(1'b1, 24'h50, 1, 3'd2, 2'b10, 0, 1'b0);
    axi_read(1'b0, 24'h50, 2, 3'd1, 2'b01, 0, 2);
    n_cmp++;
    if (mem_en_cnt != en0 || ram[20] !== 32'h0) begin
      n_err++;
      $display("FAIL err_no_mem: got %0d mem accesses word20=%h, required 0 and 0",
               mem_en_cnt - en0, ram[20]);
    end
  endtask

  task automatic test_boundary();
    // INCR wraps from the top word back to word 0; FIXED hammers one word.
    wdat[0] = 32'hCAFE_0001; wstb[0] = 4'hF;
    wdat[1] = 32'hCAFE_0002; wstb[1] = 4'hF;
    axi_write(1'b0, 24'hFF_FFFC, 1, 3'd2, 2'b01, 0, 1'b0);
    axi_read(1'b0, 24'hFF_FFFE, 1, 3'd2, 2'b01, 0, 1);
    wdat[0] = 32'h1111_1111; wstb[0] = 4'hF;
    wdat[1] = 32'h2222_2222; wstb[1] = 4'h3;
    wdat[2] = 32'h3333_3333; wstb[2] = 4'h8;
    axi_write(1'b1, 24'h61, 2, 3'd2, 2'b00, 0, 1'b0);
    axi_read(1'b1, 24'h60, 1, 3'd2, 2'b00, 0, 1);
  endtask

  task automatic test_reset_mid();
    awid = 1'b0; awaddr = 24'h3000; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01;
    awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    wdata = 32'h5A5A_0000; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
    @(negedge clk);
    wdata = 32'h5A5A_0001;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({awready, arready, wready, bvalid, rvalid, mem_en, mem_we} !== '0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: got aw=%b ar=%b w=%b b=%b r=%b en=%b we=%h, required 0",
               awready, arready, wready, bvalid, rvalid, mem_en, mem_we);
    end
    rst = 1'b0; wvalid = 1'b0;
    #1;
    n_cmp++;
    if ({awready, wready, bvalid} !== 3'b100) begin
      n_err++;
      $display("FAIL rst_mid_idle: got aw/w/b=%b%b%b, required 100", awready, wready, bvalid);
    end
    n_cmp++;
    if (ram[12'hC00] !== 32'h5A5A_0000 || ram[12'hC01] !== 32'h0) begin
      n_err++;
      $display("FAIL rst_mid_mem: got %h %h, required 5a5a0000 00000000",
               ram[12'hC00], ram[12'hC01]);
    end
    @(negedge clk);
    wdat[0] = 32'h0BAD_F00D; wstb[0] = 4'hF;
    wdat[1] = 32'h600D_F00D; wstb[1] = 4'hF;
    axi_write(1'b1, 24'h70, 1, 3'd2, 2'b01, 0, 1'b0);
    axi_read(1'b1, 24'h70, 1, 3'd2, 2'b01, 0, 0);
  endtask

  task automatic test_random();
    int len, r;
    logic [1:0] burst;
    logic [2:0] size;
    logic [23:0] a;
    for (int t = 0; t < 30; t++) begin
      len = $urandom_range(7, 0);
      a = 24'({$urandom_range(63, 0), 2'($urandom)});
      r = $urandom_range(7, 0);
      burst = (r == 0) ? 2'b00 : (r == 6) ? 2'b10 : (r == 7) ? 2'b11 : 2'b01;
      size = ($urandom_range(7, 0) == 0) ? 3'd1 : 3'd2;
      if ($urandom_range(1, 0) == 1) begin
        for (int i = 0; i <= len; i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom); end
        axi_write(1'($urandom), a, len, size, burst, $urandom_range(3, 0), 1'b0);
      end else begin
        axi_read(1'($urandom), a, len, size, burst, 0, 3);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0;
    for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
    @(negedge clk);
    test_reset();
    test_single();
    test_burst();
    test_priority();
    test_stall();
    test_error();
    test_boundary();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
